// File: rtl/imm_encoder.sv
// RISC-V I/S/B immediate encoder feeding an instruction-memory writer; IMM_RANGE_CHECK_EN enables immediate range checking.
// Latency: out_valid one edge after accept; the word is held until out_ready, and in_ready is high only while idle.
module imm_encoder #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_imm_src,
  input  logic [31:0]       in_imm,
  input  logic [24:0]       in_hi,
  input  logic [6:0]        in_opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_wrap,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

`ifdef IMM_RANGE_CHECK_EN
  localparam int IMM_W = 32;
`else
  // Without range checking only imm[12:0] can reach the instruction word.
  localparam int IMM_W = 13;
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:13];
`endif

  logic [1:0]        state_q,   state_d;
  logic [1:0]        src_q,     src_d;
  logic [IMM_W-1:0]  imm_q,     imm_d;
  logic [24:0]       hi_q,      hi_d;
  logic [6:0]        op_q,      op_d;
  logic [31:0]       instr_q,   instr_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              wrap_q,    wrap_d;
  logic              err_q,     err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] enc_word;
  logic        enc_ok;

  always_comb begin
    enc_word = {hi_q, op_q};
    enc_ok   = 1'b1;
    case (src_q)
      SRC_I: begin
        enc_word[31:20] = imm_q[11:0];
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
`endif
      end
      SRC_S: begin
        enc_word[31:25] = imm_q[11:5];
        enc_word[11:7]  = imm_q[4:0];
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
`endif
      end
      SRC_B: begin
        enc_word[31]    = imm_q[12];
        enc_word[30:25] = imm_q[10:5];
        enc_word[11:8]  = imm_q[4:1];
        enc_word[7]     = imm_q[11];
`ifdef IMM_RANGE_CHECK_EN
        enc_ok = ((imm_q[31:12] == '0) || (imm_q[31:12] == '1)) && !imm_q[0];
`endif
      end
      default: enc_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    imm_d     = imm_q;
    hi_d      = hi_q;
    op_d      = op_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_imm_src;
          imm_d   = in_imm[IMM_W-1:0];
          hi_d    = in_hi;
          op_d    = in_opcode;
          state_d = ENC;
        end
      end
      ENC: begin
        if (enc_ok) begin
          instr_d = enc_word;
          state_d = HOLD;
        end else begin
          err_d     = 1'b1;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          addr_d  = addr_q + 1'b1;
          wrap_d  = &addr_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over any handshake or rejection in the same cycle.
    if (clr) begin
      state_d   = IDLE;
      addr_d    = START_ADDR;
      err_cnt_d = err_cnt_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      imm_q     <= '0;
      hi_q      <= '0;
      op_q      <= '0;
      instr_q   <= '0;
      addr_q    <= START_ADDR;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      hi_q      <= hi_d;
      op_q      <= op_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign out_wrap  = wrap_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a 2-bit address so wrap-around is reachable.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [24:0] in_hi;
  logic [6:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        out_wrap;
  logic        err;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  imm_encoder #(.ADDR_W(2), .START_ADDR(2'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm_src(in_imm_src),
    .in_imm    (in_imm),
    .in_hi     (in_hi),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_wrap  (out_wrap),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle, then steps past the ENC cycle.
  task automatic send(input logic [1:0] s, input logic [31:0] imm,
                      input logic [24:0] hi, input logic [6:0] op);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_imm_src = s;
    in_imm     = imm;
    in_hi      = hi;
    in_opcode  = op;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    chk("in_ready_enc", {31'd0, in_ready}, 32'd0);
    tick();
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr, input logic [1:0] addr);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"},  {30'd0, out_addr}, {30'd0, addr});
    chk({tag, "_noerr"}, {31'd0, err}, 32'd0);
  endtask

  task automatic handshake(input logic [1:0] nxt, input logic wrap);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_low", {31'd0, out_valid}, 32'd0);
    chk("hs_addr",      {30'd0, out_addr}, {30'd0, nxt});
    chk("hs_wrap",      {31'd0, out_wrap}, {31'd0, wrap});
  endtask

  task automatic expect_err(input logic [7:0] cnt, input logic [1:0] addr);
    chk("err_pulse",    {31'd0, err}, 32'd1);
    chk("err_novalid",  {31'd0, out_valid}, 32'd0);
    chk("err_cnt",      {24'd0, err_cnt}, {24'd0, cnt});
    chk("err_addr",     {30'd0, out_addr}, {30'd0, addr});
    chk("err_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("err_one_cycle", {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [7:0] errs;
    errs       = 8'd0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_imm_src = 2'b00;
    in_imm     = 32'd0;
    in_hi      = 25'd0;
    in_opcode  = 7'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {30'd0, out_addr}, 32'd0);
    chk("rst_out_wrap", {31'd0, out_wrap}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // I-type, most negative 12-bit immediate
    send(2'b00, 32'hFFFFF800, 25'd0, 7'h13);
    expect_word("i_neg", 32'h80000013, 2'd0);
    handshake(2'd1, 1'b0);

    // S-type with a five-cycle downstream stall
    send(2'b01, 32'h0000007F, 25'd0, 7'h23);
    expect_word("s_pos", 32'h06000FA3, 2'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_instr", out_instr, 32'h06000FA3);
      chk("stall_addr", {30'd0, out_addr}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    handshake(2'd2, 1'b0);
    tick();
    chk("single_hs_addr", {30'd0, out_addr}, 32'd2);

    // B-type, -2
    send(2'b10, 32'hFFFFFFFE, 25'd0, 7'h63);
    expect_word("b_neg", 32'hFE000FE3, 2'd2);
    handshake(2'd3, 1'b0);

    // Illegal format is always rejected
    send(2'b11, 32'd0, 25'd0, 7'h13);
    errs = errs + 8'd1;
    expect_err(errs, 2'd3);

`ifdef IMM_RANGE_CHECK_EN
    send(2'b10, 32'h00000003, 25'd0, 7'h63);
    errs = errs + 8'd1;
    expect_err(errs, 2'd3);
    send(2'b00, 32'h00000800, 25'd0, 7'h13);
    errs = errs + 8'd1;
    expect_err(errs, 2'd3);
`else
    send(2'b10, 32'h00000003, 25'd0, 7'h63);
    expect_word("b_trunc", 32'h00000163, 2'd3);
    handshake(2'd0, 1'b1);
    tick();
    chk("wrap_pulse_end", {31'd0, out_wrap}, 32'd0);
    send(2'b00, 32'h00000800, 25'd0, 7'h13);
    expect_word("i_trunc", 32'h80000013, 2'd0);
    handshake(2'd1, 1'b0);
    chk("trunc_err_cnt", {24'd0, err_cnt}, {24'd0, errs});
`endif

    // Idle clear returns the address to its start value
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_addr", {30'd0, out_addr}, 32'd0);
    chk("clr_err_cnt", {24'd0, err_cnt}, {24'd0, errs});

    // Four words fill the 2-bit address space and wrap
    send(2'b00, 32'h00000005, 25'h1FFFFFF, 7'h13);
    expect_word("w0", 32'h005FFF93, 2'd0);
    handshake(2'd1, 1'b0);
    send(2'b01, 32'h00000000, 25'h1FFFFFF, 7'h23);
    expect_word("w1", 32'h01FFF023, 2'd1);
    handshake(2'd2, 1'b0);
    send(2'b10, 32'h00000800, 25'd0, 7'h63);
    expect_word("w2", 32'h000000E3, 2'd2);
    handshake(2'd3, 1'b0);
    send(2'b10, 32'hFFFFF000, 25'd0, 7'h63);
    expect_word("w3", 32'h80000063, 2'd3);
    handshake(2'd0, 1'b1);
    tick();
    chk("wrap2_pulse_end", {31'd0, out_wrap}, 32'd0);

    // Clear during HOLD beats a simultaneous handshake
    send(2'b00, 32'h00000001, 25'd0, 7'h13);
    expect_word("c0", 32'h00100013, 2'd0);
    handshake(2'd1, 1'b0);
    send(2'b00, 32'h00000001, 25'd0, 7'h13);
    expect_word("c1", 32'h00100013, 2'd1);
    clr       = 1'b1;
    out_ready = 1'b1;
    tick();
    clr       = 1'b0;
    out_ready = 1'b0;
    chk("clr_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_hold_addr", {30'd0, out_addr}, 32'd0);
    chk("clr_hold_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_hold_err_cnt", {24'd0, err_cnt}, {24'd0, errs});
    chk("clr_hold_wrap", {31'd0, out_wrap}, 32'd0);

    // Reset during HOLD discards the word
    send(2'b01, 32'h0000007F, 25'd0, 7'h23);
    expect_word("r0", 32'h06000FA3, 2'd0);
    handshake(2'd1, 1'b0);
    send(2'b01, 32'h0000007F, 25'd0, 7'h23);
    expect_word("r1", 32'h06000FA3, 2'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_hold_addr", {30'd0, out_addr}, 32'd0);
    chk("rst_hold_instr", out_instr, 32'd0);
    chk("rst_hold_err", {31'd0, err}, 32'd0);
    chk("rst_hold_err_cnt", {24'd0, err_cnt}, 32'd0);
    tick();
    chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_hold_addr2", {30'd0, out_addr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 Parameter START_ADDR, default 0, address loaded on reset and on clr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clr  input  1  synchronous clear of state machine and address counter.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 in_imm_src  input  2  immediate format: 00 I, 01 S, 10 B, 11 illegal.
REQ-009 in_imm  input  32  signed immediate to encode.
REQ-010 in_hi  input  25  non-immediate instruction bits [31:7] (rd, funct3, rs1, rs2, funct7).
REQ-011 in_opcode  input  7  instruction bits [6:0].
REQ-012 out_valid  output  1  encoded instruction valid.
REQ-013 out_ready  input  1  downstream (instruction-memory writer) accepts.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_addr  output  ADDR_W  word address for out_instr.
REQ-016 out_wrap  output  1  one-cycle pulse when out_addr wraps to 0.
REQ-017 err  output  1  one-cycle pulse on a rejected request.
REQ-018 err_cnt  output  8  saturating count of rejected requests.

Function
REQ-019 States IDLE, ENC, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on in_valid, capture all in_* fields into an internal register, go to ENC.
REQ-021 ENC: encode and check; pass -> load output register, out_valid=1, go HOLD; fail -> err=1 for one cycle, err_cnt+1 (saturate at 255), go IDLE, out_addr unchanged.
REQ-022 Base word {in_hi, in_opcode}; immediate bits overwrite: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
REQ-023 in_imm_src=11 SHALL always fail.
REQ-024 HOLD: out_valid, out_instr, out_addr held stable until out_ready; on handshake go IDLE, out_valid=0, out_addr+1.
REQ-025 out_addr SHALL wrap from 2^ADDR_W-1 to 0; out_wrap pulses in the cycle after that handshake.
REQ-026 Latency: accept at edge N -> out_valid visible after edge N+1; best throughput one word per 3 cycles.
REQ-027 clr SHALL override any simultaneous handshake: state IDLE, out_valid=0, out_addr=START_ADDR, err_cnt unchanged, pending word discarded.

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, in_ready=1 after reset, out_valid=0, out_instr=0, out_addr=START_ADDR, out_wrap=0, err=0, err_cnt=0.
REQ-029 Reset asserted in ENC or HOLD SHALL discard the pending word without err or address increment.

Configuration
REQ-030 Macro IMM_RANGE_CHECK_EN defined: I/S fail unless in_imm[31:11] all equal; B fails unless in_imm[31:12] all equal and in_imm[0]=0.
REQ-031 Macro undefined: no range check, upper bits silently truncated (B drops imm[0]); only in_imm_src=11 fails.

Verification
REQ-032 I, imm=0xFFFFF800, in_hi=0, opcode=0x13 -> out_instr=0x80000013, out_addr=0.
REQ-033 S, imm=0x0000007F, in_hi=0, opcode=0x23 -> out_instr=0x06000FA3, out_addr=1 on next word.
REQ-034 B, imm=0xFFFFFFFE, in_hi=0, opcode=0x63 -> out_instr=0xFE000FE3.
REQ-035 With IMM_RANGE_CHECK_EN: B imm=0x00000003, then I imm=0x00000800 -> two err pulses, err_cnt=2, no out_valid, out_addr unchanged; without macro both emit.
REQ-036 out_ready low 5 cycles in HOLD -> out_instr/out_addr stable, in_ready=0; release -> single handshake, out_addr+1.
REQ-037 ADDR_W=2: four words -> addresses 0,1,2,3, then out_addr=0 with out_wrap pulse; clr or rst_n=0 during HOLD -> out_valid=0, out_addr=START_ADDR.
